// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART oversampling baud generator.
package uart_pkg;

  localparam int OSR_DEFAULT    = 16;
  localparam int DIV_MIN        = 2;
  localparam int DIV_9600_50M   = 325;
  localparam int DIV_115200_50M = 27;

  function automatic logic div_legal(input logic [31:0] i_div);
    return (i_div >= $unsigned(DIV_MIN));
  endfunction

endpackage

// File: rtl/uart_baud_gen_os_if.sv
// Control/status bundle of the baud generator; div_frac_i exists only with UART_BAUD_FRAC_EN.
interface uart_baud_gen_os_if #(
  parameter int DIV_W = 16,
  parameter int OSR   = 16
);
  localparam int PH_W = $clog2(OSR);

  logic             enable;
  logic             resync;
  logic [DIV_W-1:0] div_i;
  logic             div_load;
`ifdef UART_BAUD_FRAC_EN
  logic [3:0]       div_frac_i;
`endif
  logic             os_tick;
  logic             sample_tick;
  logic             bit_tick;
  logic [PH_W-1:0]  phase;
  logic             div_err;

  modport master (
    output enable, resync, div_i, div_load,
`ifdef UART_BAUD_FRAC_EN
    output div_frac_i,
`endif
    input  os_tick, sample_tick, bit_tick, phase, div_err
  );

  modport slave (
    input  enable, resync, div_i, div_load,
`ifdef UART_BAUD_FRAC_EN
    input  div_frac_i,
`endif
    output os_tick, sample_tick, bit_tick, phase, div_err
  );
endinterface

// File: rtl/uart_baud_gen_os_prescaler.sv
// Prescaler: divisor/pending registers, pre_cnt and os_tick generation.
// UART_BAUD_FRAC_EN adds a 4-bit fractional accumulator stretching some periods by one cycle.
module uart_prescaler
  import uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = DIV_115200_50M
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_resync,
  input  logic             i_div_load,
  input  logic [DIV_W-1:0] i_div,
`ifdef UART_BAUD_FRAC_EN
  input  logic [3:0]       i_div_frac,
`endif
  input  logic             i_bit_edge,
  output logic             o_term,
  output logic             o_os_tick,
  output logic             o_div_err
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] r_pre_cnt;
  logic [DIV_W-1:0] r_div_q;
  logic [DIV_W-1:0] r_pend;
  logic             r_pend_valid;
  logic             r_os_tick;
  logic             r_div_err;
  logic [DIV_W-1:0] w_last;
  logic             w_load_ok;
  logic             w_take_now;
  logic             w_take_pend;
  logic             w_store;

  assign w_load_ok   = i_div_load & div_legal(32'(i_div));
  // While idle, or exactly on a bit boundary, a legal divisor applies at once.
  assign w_take_now  = w_load_ok & (~i_enable | i_bit_edge);
  assign w_take_pend = ~w_take_now & i_bit_edge & r_pend_valid;
  assign w_store     = w_load_ok & ~w_take_now;

`ifdef UART_BAUD_FRAC_EN
  logic [3:0] r_frac_q;
  logic [3:0] r_frac_pend;
  logic [3:0] r_acc;
  logic       r_extend;

  assign w_last = r_div_q - ONE + {{(DIV_W-1){1'b0}}, r_extend};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frac_q    <= 4'd0;
      r_frac_pend <= 4'd0;
    end else if (w_take_now) begin
      r_frac_q    <= i_div_frac;
    end else if (w_take_pend) begin
      r_frac_q    <= r_frac_pend;
    end else if (w_store) begin
      r_frac_pend <= i_div_frac;
    end else begin
      r_frac_q    <= r_frac_q;
    end
  end

  // A carry out of the accumulator lengthens the following period by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= 4'd0;
      r_extend <= 1'b0;
    end else if (!i_enable || i_resync) begin
      r_acc    <= 4'd0;
      r_extend <= 1'b0;
    end else if (o_term) begin
      {r_extend, r_acc} <= {1'b0, r_acc} + {1'b0, r_frac_q};
    end else begin
      r_acc    <= r_acc;
    end
  end
`else
  assign w_last = r_div_q - ONE;
`endif

  assign o_term    = i_enable & ~i_resync & (r_pre_cnt == w_last);
  assign o_os_tick = r_os_tick;
  assign o_div_err = r_div_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre_cnt <= '0;
      r_os_tick <= 1'b0;
    end else if (!i_enable || i_resync) begin
      r_pre_cnt <= '0;
      r_os_tick <= 1'b0;
    end else if (o_term) begin
      r_pre_cnt <= '0;
      r_os_tick <= 1'b1;
    end else begin
      r_pre_cnt <= r_pre_cnt + ONE;
      r_os_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_q      <= DIV_W'(DEFAULT_DIV);
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_div_err    <= 1'b0;
    end else begin
      r_div_err <= i_div_load & ~w_load_ok;
      if (w_take_now) begin
        r_div_q      <= i_div;
        r_pend_valid <= 1'b0;
      end else if (w_take_pend) begin
        r_div_q      <= r_pend;
        r_pend_valid <= 1'b0;
      end else if (w_store) begin
        r_pend       <= i_div;
        r_pend_valid <= 1'b1;
      end else begin
        r_pend_valid <= r_pend_valid;
      end
    end
  end

endmodule

// File: rtl/uart_baud_gen_os.sv
// Oversampling baud generator: phase counter, mid-bit and bit-end strobes, start-bit resync.
// Optional fractional divisor enabled by UART_BAUD_FRAC_EN.
module uart_baud_gen_os
  import uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int OSR         = OSR_DEFAULT,
  parameter int DEFAULT_DIV = DIV_115200_50M
) (
  input logic              clk,
  input logic              reset,
  uart_baud_gen_os_if.slave bus
);

  localparam int              PH_W    = $clog2(OSR);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OSR / 2 - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  logic [PH_W-1:0] r_phase;
  logic            r_sample_tick;
  logic            r_bit_tick;
  logic            w_term;
  logic            w_bit_edge;

  assign w_bit_edge      = w_term & (r_phase == PH_LAST);
  assign bus.phase       = r_phase;
  assign bus.sample_tick = r_sample_tick;
  assign bus.bit_tick    = r_bit_tick;

  uart_prescaler #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .i_enable   (bus.enable),
    .i_resync   (bus.resync),
    .i_div_load (bus.div_load),
    .i_div      (bus.div_i),
`ifdef UART_BAUD_FRAC_EN
    .i_div_frac (bus.div_frac_i),
`endif
    .i_bit_edge (w_bit_edge),
    .o_term     (w_term),
    .o_os_tick  (bus.os_tick),
    .o_div_err  (bus.div_err)
  );

  // Resync shares the disable path so a coincident terminal count never produces strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase       <= '0;
      r_sample_tick <= 1'b0;
      r_bit_tick    <= 1'b0;
    end else if (!bus.enable || bus.resync) begin
      r_phase       <= '0;
      r_sample_tick <= 1'b0;
      r_bit_tick    <= 1'b0;
    end else begin
      r_sample_tick <= w_term & (r_phase == PH_MID);
      r_bit_tick    <= w_bit_edge;
      if (w_term) begin
        r_phase <= r_phase + PH_ONE;
      end else begin
        r_phase <= r_phase;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen_os.sv
// Self-checking bench for uart_baud_gen_os: directed latency scenarios plus randomized
// traffic compared cycle by cycle against an elapsed-cycle reference model.
module tb_uart_baud_gen_os;
  import uart_pkg::*;

  localparam int DIV_W = 16;
  localparam int OSR   = 16;
  localparam int DEF   = 27;

  logic clk = 1'b0;
  logic reset;

  uart_baud_gen_os_if #(.DIV_W(DIV_W), .OSR(OSR)) bus ();

  uart_baud_gen_os #(.DIV_W(DIV_W), .OSR(OSR), .DEFAULT_DIV(DEF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: cycles elapsed in the current oversample period and ticks in the bit.
  int m_cnt, m_ticks, m_div, m_pend;
  bit e_os, e_s, e_b, e_err, m_on;

  task automatic model_reset();
    m_cnt = 0; m_ticks = 0; m_div = DEF; m_pend = -1;
    e_os = 0; e_s = 0; e_b = 0; e_err = 0;
  endtask

  task automatic model_edge();
    int dv;
    bit ld, legal;
    dv = int'(bus.div_i);
    ld = bus.div_load;
    legal = ld && (dv >= 2);
    e_err = ld && (dv < 2);
    e_os = 0; e_s = 0; e_b = 0;
    if (!bus.enable) begin
      m_cnt = 0; m_ticks = 0;
      if (legal) begin m_div = dv; m_pend = -1; end
    end else if (bus.resync) begin
      m_cnt = 0; m_ticks = 0;
      if (legal) m_pend = dv;
    end else begin
      m_cnt++;
      if (m_cnt == m_div) begin
        m_cnt = 0; e_os = 1; m_ticks++;
        e_s = (m_ticks == OSR / 2);
        e_b = (m_ticks == OSR);
        if (e_b) begin
          m_ticks = 0;
          if (legal) begin m_div = dv; m_pend = -1; legal = 0; end
          else if (m_pend >= 0) begin m_div = m_pend; m_pend = -1; end
        end
      end
      if (legal) m_pend = dv;
    end
  endtask

  // One clock edge: inputs held across posedge, model advanced and outputs checked at negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    model_edge();
    if (m_on) begin
      check("os_tick", bus.os_tick, e_os);
      check("sample_tick", bus.sample_tick, e_s);
      check("bit_tick", bus.bit_tick, e_b);
      check("phase", bus.phase, m_ticks % OSR);
      check("div_err", bus.div_err, e_err);
    end
    bus.div_load = 1'b0;
    bus.resync   = 1'b0;
  endtask

  task automatic run_until(input int which, input int budget, output int edges);
    bit seen;
    edges = 0;
    seen = 0;
    while (!seen && edges < budget) begin
      step();
      edges++;
      case (which)
        0:       seen = bus.os_tick;
        1:       seen = bus.sample_tick;
        2:       seen = bus.bit_tick;
        default: seen = 1'b1;
      endcase
    end
    if (!seen) edges = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int e1, e2, e3, guard;
    reset = 1'b1;
    bus.enable = 1'b0; bus.resync = 1'b0; bus.div_load = 1'b0; bus.div_i = '0;
`ifdef UART_BAUD_FRAC_EN
    bus.div_frac_i = 4'd0;
`endif
    m_on = 0;
    model_reset();
    #12;
    check("rst_os", bus.os_tick, 0);
    check("rst_sample", bus.sample_tick, 0);
    check("rst_bit", bus.bit_tick, 0);
    check("rst_phase", bus.phase, 0);
    check("rst_err", bus.div_err, 0);
    @(negedge clk);
    reset = 1'b0;
    m_on = 1;
    bus.enable = 1'b1;

    // Default divisor latency and bit period.
    run_until(0, 1000, e1); check("lat_os_27", e1, 27);
    run_until(1, 1000, e2); check("lat_sample_27", e1 + e2, 216);
    run_until(2, 1000, e3); check("lat_bit_27", e1 + e2 + e3, 432);
    run_until(2, 1000, e1); check("bit_period_27", e1, 432);

    // Load D=4 while idle, then restart.
    bus.enable = 1'b0; step();
    bus.div_i = 16'd4; bus.div_load = 1'b1; step();
    bus.enable = 1'b1;
    run_until(0, 100, e1); check("lat_os_4", e1, 4);
    run_until(1, 100, e2); check("lat_sample_4", e1 + e2, 32);
    run_until(2, 100, e3); check("lat_bit_4", e1 + e2 + e3, 64);

    // Resync on a terminal-count edge drops that tick and re-phases.
    repeat (47) step();
    bus.resync = 1'b1; step();
    check("resync_drop", bus.os_tick, 0);
    run_until(1, 200, e1); check("resync_sample", e1, 32);
    run_until(2, 200, e2); check("resync_bit", e1 + e2, 64);

    // Mid-bit load takes effect at the bit boundary; illegal load flags an error.
    repeat (10) step();
    bus.div_i = 16'd8; bus.div_load = 1'b1; step();
    run_until(0, 100, e1);
    run_until(0, 100, e1); check("pend_old_period", e1, 4);
    run_until(2, 200, e1);
    run_until(0, 100, e1); check("pend_new_period", e1, 8);
    bus.div_i = 16'd1; bus.div_load = 1'b1; step();
    check("div_err_pulse", bus.div_err, 1);
    run_until(0, 100, e1);
    run_until(0, 100, e1); check("err_keeps_div", e1, 8);

    // Asynchronous reset mid-bit with a pending divisor.
    guard = 0;
    while (bus.phase != 4'd9 && guard < 2000) begin step(); guard++; end
    check("reach_phase9", bus.phase, 9);
    bus.div_i = 16'd4; bus.div_load = 1'b1; step();
    #2 reset = 1'b1;
    #1;
    check("arst_os", bus.os_tick, 0);
    check("arst_sample", bus.sample_tick, 0);
    check("arst_bit", bus.bit_tick, 0);
    check("arst_phase", bus.phase, 0);
    check("arst_err", bus.div_err, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    run_until(0, 1000, e1); check("arst_lat_os", e1, 27);
    run_until(2, 1000, e2); check("arst_lat_bit", e1 + e2, 432);
    run_until(0, 1000, e1); check("arst_pend_dropped", e1, 27);

    // Randomized traffic with short divisors against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.enable = ($urandom_range(99) < 97);
      bus.resync = ($urandom_range(99) < 1);
      if ($urandom_range(99) < 2) begin
        bus.div_i = 16'($urandom_range(9));
        bus.div_load = 1'b1;
      end
      step();
    end

`ifdef UART_BAUD_FRAC_EN
    // Fractional divisor 4 + 8/16: periods alternate 4 and 5.
    m_on = 0;
    bus.enable = 1'b0; step();
    bus.div_i = 16'd4; bus.div_frac_i = 4'd8; bus.div_load = 1'b1; step();
    bus.enable = 1'b1;
    run_until(0, 100, e1); check("frac_first", e1, 4);
    e2 = 0;
    for (int k = 0; k < 16; k++) begin
      run_until(0, 100, e1);
      e2 += e1;
    end
    check("frac_16_ticks", e2, 72);
    run_until(0, 100, e1); check("frac_period_a", e1, 4);
    run_until(0, 100, e1); check("frac_period_b", e1, 5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
